halt_controller: RTL and testbench

- Sequences the pipeline into and out of the halted state when the halt decode flags a SYSTEM instruction (ECALL/EBREAK) in ID.
- Freezes fetch, bubbles ID/EX, lets older instructions drain through EX/MEM/WB, then holds a stable HALTED state.
- Resumes by redirecting PC past the halting instruction.
- Sits beside the hazard unit and drives the PC, IF/ID and ID/EX control pins.

---
 rtl/halt_if.sv | 46 ++++
 rtl/halt_controller.sv | 162 ++++++++++++++++
 tb/tb_halt_controller.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/halt_if.sv
// Halt controller port bundle: ID-stage halt decode and debug requests in, pipeline control pins out.
// The step_req signal exists only when HALT_SINGLE_STEP_EN is defined.
interface halt_if #(
    parameter int PC_WIDTH = 32
);
    logic                halt_req;
    logic                ebreak_bit;
    logic [PC_WIDTH-1:0] id_pc;
    logic                resume_req;
`ifdef HALT_SINGLE_STEP_EN
    logic                step_req;
`endif
    logic                pc_write_en;
    logic                if_id_write_en;
    logic                if_id_flush;
    logic                id_ex_bubble;
    logic                pc_redirect_valid;
    logic [PC_WIDTH-1:0] pc_redirect;
    logic                halted;
    logic [1:0]          halt_cause;
    logic [PC_WIDTH-1:0] halt_pc;

`ifdef HALT_SINGLE_STEP_EN
    modport master (
        input  halt_req, ebreak_bit, id_pc, resume_req, step_req,
        output pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble,
               pc_redirect_valid, pc_redirect, halted, halt_cause, halt_pc
    );
    modport slave (
        output halt_req, ebreak_bit, id_pc, resume_req, step_req,
        input  pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble,
               pc_redirect_valid, pc_redirect, halted, halt_cause, halt_pc
    );
`else
    modport master (
        input  halt_req, ebreak_bit, id_pc, resume_req,
        output pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble,
               pc_redirect_valid, pc_redirect, halted, halt_cause, halt_pc
    );
    modport slave (
        output halt_req, ebreak_bit, id_pc, resume_req,
        input  pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble,
               pc_redirect_valid, pc_redirect, halted, halt_cause, halt_pc
    );
`endif
endinterface

// File: rtl/halt_controller.sv
// Halts the pipeline on ECALL/EBREAK in ID, drains older instructions, holds HALTED, resumes past the SYSTEM op.
// Define HALT_SINGLE_STEP_EN to add step_req and the one-instruction STEP state.
module halt_controller #(
    parameter int PC_WIDTH     = 32,
    parameter int DRAIN_CYCLES = 3
) (
    input logic     clk,
    input logic     rst,
    halt_if.master  bus
);

`ifdef HALT_SINGLE_STEP_EN
    typedef enum logic [3:0] {
        S_RUN    = 4'd0,
        S_DRAIN  = 4'd1,
        S_HALTED = 4'd2,
        S_STEP   = 4'd3
    } state_t;
`else
    typedef enum logic [3:0] {
        S_RUN    = 4'd0,
        S_DRAIN  = 4'd1,
        S_HALTED = 4'd2
    } state_t;
`endif

    localparam logic [1:0] CAUSE_NONE   = 2'b00;
    localparam logic [1:0] CAUSE_EBREAK = 2'b01;
    localparam logic [1:0] CAUSE_ECALL  = 2'b10;
`ifdef HALT_SINGLE_STEP_EN
    localparam logic [1:0] CAUSE_STEP   = 2'b11;
`endif

    state_t              state, state_nxt;
    logic [3:0]          drain_cnt, drain_cnt_nxt;
    logic                halted_q, halted_nxt;
    logic [1:0]          cause_q, cause_nxt;
    logic [PC_WIDTH-1:0] halt_pc_q, halt_pc_nxt;
    logic                resume_flag, resume_flag_nxt;
    logic [PC_WIDTH-1:0] next_pc;
`ifdef HALT_SINGLE_STEP_EN
    logic                step_first, step_first_nxt;
`endif

    assign next_pc = halt_pc_q + PC_WIDTH'(4);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_RUN;
            drain_cnt   <= 4'd0;
            halted_q    <= 1'b0;
            cause_q     <= CAUSE_NONE;
            halt_pc_q   <= '0;
            resume_flag <= 1'b0;
`ifdef HALT_SINGLE_STEP_EN
            step_first  <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            drain_cnt   <= drain_cnt_nxt;
            halted_q    <= halted_nxt;
            cause_q     <= cause_nxt;
            halt_pc_q   <= halt_pc_nxt;
            resume_flag <= resume_flag_nxt;
`ifdef HALT_SINGLE_STEP_EN
            step_first  <= step_first_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt             = state;
        drain_cnt_nxt         = drain_cnt;
        halted_nxt            = halted_q;
        cause_nxt             = cause_q;
        halt_pc_nxt           = halt_pc_q;
        resume_flag_nxt       = 1'b0;
`ifdef HALT_SINGLE_STEP_EN
        step_first_nxt        = 1'b0;
`endif
        bus.pc_write_en       = 1'b1;
        bus.if_id_write_en    = 1'b1;
        bus.if_id_flush       = 1'b0;
        bus.id_ex_bubble      = 1'b0;
        bus.pc_redirect_valid = 1'b0;
        bus.pc_redirect       = '0;

        case (state)
            S_RUN: begin
                // IF/ID was flushed on resume, so a halt_req seen in that first cycle is stale.
                if (bus.halt_req && !resume_flag) begin
                    bus.pc_write_en    = 1'b0;
                    bus.if_id_write_en = 1'b0;
                    bus.id_ex_bubble   = 1'b1;
                    halt_pc_nxt        = bus.id_pc;
                    cause_nxt          = bus.ebreak_bit ? CAUSE_EBREAK : CAUSE_ECALL;
                    drain_cnt_nxt      = 4'(DRAIN_CYCLES - 1);
                    state_nxt          = S_DRAIN;
                end
            end
            S_DRAIN: begin
                bus.pc_write_en    = 1'b0;
                bus.if_id_write_en = 1'b0;
                bus.id_ex_bubble   = 1'b1;
`ifdef HALT_SINGLE_STEP_EN
                // The stepped instruction sits in IF/ID and must be let into EX once.
                if (step_first)
                    bus.id_ex_bubble = 1'b0;
`endif
                if (drain_cnt == 4'd0) begin
                    state_nxt  = S_HALTED;
                    halted_nxt = 1'b1;
                end else begin
                    drain_cnt_nxt = drain_cnt - 4'd1;
                end
            end
            S_HALTED: begin
                bus.pc_write_en    = 1'b0;
                bus.if_id_write_en = 1'b0;
                bus.id_ex_bubble   = 1'b1;
                if (bus.resume_req) begin
                    bus.pc_redirect_valid = 1'b1;
                    bus.pc_redirect       = next_pc;
                    bus.pc_write_en       = 1'b1;
                    bus.if_id_flush       = 1'b1;
                    state_nxt             = S_RUN;
                    halted_nxt            = 1'b0;
                    cause_nxt             = CAUSE_NONE;
                    resume_flag_nxt       = 1'b1;
                end
`ifdef HALT_SINGLE_STEP_EN
                else if (bus.step_req) begin
                    bus.pc_redirect_valid = 1'b1;
                    bus.pc_redirect       = next_pc;
                    bus.pc_write_en       = 1'b1;
                    bus.if_id_flush       = 1'b1;
                    state_nxt             = S_STEP;
                    halted_nxt            = 1'b0;
                end
`endif
            end
`ifdef HALT_SINGLE_STEP_EN
            S_STEP: begin
                // One fetch slot; the extra drain cycle covers the stepped instruction itself.
                halt_pc_nxt    = next_pc;
                cause_nxt      = CAUSE_STEP;
                drain_cnt_nxt  = 4'(DRAIN_CYCLES);
                step_first_nxt = 1'b1;
                state_nxt      = S_DRAIN;
            end
`endif
            default: begin
                state_nxt = S_RUN;
            end
        endcase
    end

    assign bus.halted     = halted_q;
    assign bus.halt_cause = cause_q;
    assign bus.halt_pc    = halt_pc_q;

endmodule

// File: tb/tb_halt_controller.sv
// Directed bench for halt_controller (PC_WIDTH=32, DRAIN_CYCLES=3); step tests build with HALT_SINGLE_STEP_EN.
module tb_halt_controller;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    halt_if #(.PC_WIDTH(32)) bus ();

    halt_controller #(.PC_WIDTH(32), .DRAIN_CYCLES(3)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        bus.halt_req   = 1'b0;
        bus.ebreak_bit = 1'b0;
        bus.id_pc      = 32'h0;
        bus.resume_req = 1'b0;
`ifdef HALT_SINGLE_STEP_EN
        bus.step_req   = 1'b0;
`endif
        tick();
        tick();
        chk("rst_pc_we",    32'(bus.pc_write_en), 32'd1);
        chk("rst_ifid_we",  32'(bus.if_id_write_en), 32'd1);
        chk("rst_halted",   32'(bus.halted), 32'd0);
        chk("rst_cause",    32'(bus.halt_cause), 32'd0);
        chk("rst_halt_pc",  bus.halt_pc, 32'h0);
        chk("rst_redir",    32'(bus.pc_redirect_valid), 32'd0);
        chk("rst_redir_pc", bus.pc_redirect, 32'h0);
        chk("rst_flush",    32'(bus.if_id_flush), 32'd0);
        chk("rst_bubble",   32'(bus.id_ex_bubble), 32'd0);
        rst = 1'b0;
        tick();
        chk("run_pc_we", 32'(bus.pc_write_en), 32'd1);

        // EBREAK at 0x40: detect cycle N, drain N+1..N+3, halted at N+4
        bus.halt_req = 1'b1; bus.ebreak_bit = 1'b1; bus.id_pc = 32'h40;
        #1;
        chk("ebk_N_pc_we",  32'(bus.pc_write_en), 32'd0);
        chk("ebk_N_ifid",   32'(bus.if_id_write_en), 32'd0);
        chk("ebk_N_bubble", 32'(bus.id_ex_bubble), 32'd1);
        tick();
        bus.halt_req = 1'b0; bus.id_pc = 32'h0;
        for (int i = 1; i <= 3; i++) begin
            #1;
            chk($sformatf("ebk_N%0d_pc_we", i),  32'(bus.pc_write_en), 32'd0);
            chk($sformatf("ebk_N%0d_bubble", i), 32'(bus.id_ex_bubble), 32'd1);
            chk($sformatf("ebk_N%0d_halted", i), 32'(bus.halted), 32'd0);
            tick();
        end
        chk("ebk_halted",  32'(bus.halted), 32'd1);
        chk("ebk_cause",   32'(bus.halt_cause), 32'd1);
        chk("ebk_halt_pc", bus.halt_pc, 32'h40);
        chk("ebk_pc_we",   32'(bus.pc_write_en), 32'd0);
        chk("ebk_redir",   32'(bus.pc_redirect_valid), 32'd0);

        // Resume, then a halt_req in the first RUN cycle must be masked
        bus.resume_req = 1'b1;
        #1;
        chk("res1_redir",    32'(bus.pc_redirect_valid), 32'd1);
        chk("res1_redir_pc", bus.pc_redirect, 32'h44);
        chk("res1_flush",    32'(bus.if_id_flush), 32'd1);
        tick();
        bus.resume_req = 1'b0;
        bus.halt_req = 1'b1; bus.ebreak_bit = 1'b0; bus.id_pc = 32'h80;
        #1;
        chk("mask_pc_we",   32'(bus.pc_write_en), 32'd1);
        chk("mask_bubble",  32'(bus.id_ex_bubble), 32'd0);
        chk("mask_halted",  32'(bus.halted), 32'd0);
        chk("mask_cause",   32'(bus.halt_cause), 32'd0);
        chk("mask_redir",   32'(bus.pc_redirect_valid), 32'd0);
        tick();
        bus.halt_req = 1'b0; bus.id_pc = 32'h0;
        #1;
        chk("mask_run_pc_we", 32'(bus.pc_write_en), 32'd1);
        chk("mask_keep_pc",   bus.halt_pc, 32'h40);

        // ECALL at 0x100 with resume_req held: halt wins, drain ignores resume
        bus.halt_req = 1'b1; bus.ebreak_bit = 1'b0; bus.id_pc = 32'h100; bus.resume_req = 1'b1;
        #1;
        chk("ecl_N_pc_we", 32'(bus.pc_write_en), 32'd0);
        chk("ecl_N_redir", 32'(bus.pc_redirect_valid), 32'd0);
        tick();
        bus.halt_req = 1'b0; bus.id_pc = 32'h0;
        for (int i = 1; i <= 3; i++) begin
            #1;
            chk($sformatf("ecl_N%0d_redir", i),  32'(bus.pc_redirect_valid), 32'd0);
            chk($sformatf("ecl_N%0d_halted", i), 32'(bus.halted), 32'd0);
            tick();
        end
        bus.resume_req = 1'b0;
        #1;
        chk("ecl_halted",  32'(bus.halted), 32'd1);
        chk("ecl_cause",   32'(bus.halt_cause), 32'd2);
        chk("ecl_halt_pc", bus.halt_pc, 32'h100);
        tick();
        chk("ecl_hold_halted", 32'(bus.halted), 32'd1);
        chk("ecl_hold_cause",  32'(bus.halt_cause), 32'd2);
        bus.resume_req = 1'b1;
        #1;
        chk("res2_redir",    32'(bus.pc_redirect_valid), 32'd1);
        chk("res2_redir_pc", bus.pc_redirect, 32'h104);
        chk("res2_flush",    32'(bus.if_id_flush), 32'd1);
        chk("res2_pc_we",    32'(bus.pc_write_en), 32'd1);
        chk("res2_bubble",   32'(bus.id_ex_bubble), 32'd1);
        tick();
        bus.resume_req = 1'b0;
        #1;
        chk("res2_halted", 32'(bus.halted), 32'd0);
        chk("res2_cause",  32'(bus.halt_cause), 32'd0);
        chk("res2_redir0", 32'(bus.pc_redirect_valid), 32'd0);
        chk("res2_flush0", 32'(bus.if_id_flush), 32'd0);
        tick();

        // PC wrap on resume
        bus.halt_req = 1'b1; bus.ebreak_bit = 1'b1; bus.id_pc = 32'hFFFF_FFFC;
        tick();
        bus.halt_req = 1'b0; bus.id_pc = 32'h0;
        tick(); tick(); tick();
        chk("wrap_halted",  32'(bus.halted), 32'd1);
        chk("wrap_halt_pc", bus.halt_pc, 32'hFFFF_FFFC);
        bus.resume_req = 1'b1;
        #1;
        chk("wrap_redir",    32'(bus.pc_redirect_valid), 32'd1);
        chk("wrap_redir_pc", bus.pc_redirect, 32'h0);
        tick();
        bus.resume_req = 1'b0;
        tick();

        // Reset in the middle of DRAIN
        bus.halt_req = 1'b1; bus.ebreak_bit = 1'b0; bus.id_pc = 32'h300;
        tick();
        bus.halt_req = 1'b0; bus.id_pc = 32'h0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mrst_pc_we",   32'(bus.pc_write_en), 32'd1);
        chk("mrst_halted",  32'(bus.halted), 32'd0);
        chk("mrst_cause",   32'(bus.halt_cause), 32'd0);
        chk("mrst_halt_pc", bus.halt_pc, 32'h0);
        chk("mrst_redir",   32'(bus.pc_redirect_valid), 32'd0);
        tick(); tick(); tick(); tick();
        chk("mrst_stay_run",    32'(bus.pc_write_en), 32'd1);
        chk("mrst_stay_halted", 32'(bus.halted), 32'd0);

`ifdef HALT_SINGLE_STEP_EN
        bus.halt_req = 1'b1; bus.ebreak_bit = 1'b1; bus.id_pc = 32'h200;
        tick();
        bus.halt_req = 1'b0; bus.id_pc = 32'h0;
        tick(); tick(); tick();
        chk("stp_pre_halted", 32'(bus.halted), 32'd1);
        bus.step_req = 1'b1;
        #1;
        chk("stp_redir",    32'(bus.pc_redirect_valid), 32'd1);
        chk("stp_redir_pc", bus.pc_redirect, 32'h204);
        chk("stp_flush",    32'(bus.if_id_flush), 32'd1);
        tick();
        bus.step_req = 1'b0;
        #1;
        chk("stp_ifid_we", 32'(bus.if_id_write_en), 32'd1);
        chk("stp_pc_we",   32'(bus.pc_write_en), 32'd1);
        chk("stp_bubble",  32'(bus.id_ex_bubble), 32'd0);
        tick();
        chk("stp_d1_bubble", 32'(bus.id_ex_bubble), 32'd0);
        chk("stp_d1_halted", 32'(bus.halted), 32'd0);
        tick();
        chk("stp_d2_bubble", 32'(bus.id_ex_bubble), 32'd1);
        tick(); tick();
        chk("stp_d4_halted", 32'(bus.halted), 32'd0);
        tick();
        chk("stp_halted",  32'(bus.halted), 32'd1);
        chk("stp_halt_pc", bus.halt_pc, 32'h204);
        chk("stp_cause",   32'(bus.halt_cause), 32'd3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
